// File: rtl/lz77_match_encoder.sv
// lz77_match_encoder: serial longest-match LZ77 tokenizer emitting (offset, length, next char) triples
// Ports:
//   Clk, Rst (async, active-low)
//   In_valid/In_ready/In_last/Data_in          : byte stream in
//   Tok_valid/Tok_ready/Tok_offset/Tok_len/
//   Tok_char/Tok_last                          : token stream out
//   Busy                                       : high whenever the FSM is not idle
module lz77_match_encoder #(
    parameter int DATA_width = 8,
    parameter int WIN_num    = 64,
    parameter int WIN_addr   = 6,
    parameter int LA_num     = 16,
    parameter int LEN_width  = 4,
    parameter int OFF_width  = 7
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  In_valid,
    input  logic                  In_last,
    input  logic [DATA_width-1:0] Data_in,
    output logic                  In_ready,
    output logic                  Tok_valid,
    input  logic                  Tok_ready,
    output logic [OFF_width-1:0]  Tok_offset,
    output logic [LEN_width-1:0]  Tok_len,
    output logic [DATA_width-1:0] Tok_char,
    output logic                  Tok_last,
    output logic                  Busy
);
    localparam int LA_addr = $clog2(LA_num);
    localparam int LA_cw   = $clog2(LA_num + 1);

    typedef enum logic [2:0] {IDLE, FILL, SEARCH, EMIT, SLIDE} state_t;
    state_t state, state_nxt;

    logic [DATA_width-1:0] hist [WIN_num];
    logic [DATA_width-1:0] la [LA_num];
    logic [WIN_addr-1:0]   wp;
    logic [LA_addr-1:0]    rp;
    logic [LA_cw-1:0]      la_cnt, la_m1;
    logic [OFF_width-1:0]  hist_cnt, o, best_off;
    logic [LEN_width-1:0]  l, best_len, max_len, limit;
    logic                  last_seen, in_fire, done, eq;

    assign la_m1   = la_cnt - LA_cw'(1);
    // Longest usable match leaves at least one lookahead byte for the literal.
    assign max_len = (la_m1 < LA_cw'(LA_num - 1)) ? LEN_width'(la_m1) : LEN_width'(LA_num - 1);
    // A match may not run past the current history end into the lookahead.
    assign limit   = (o < OFF_width'(max_len)) ? LEN_width'(o) : max_len;
    assign done    = (o > hist_cnt) || (best_len == max_len);
    assign eq      = hist[wp - WIN_addr'(o) + WIN_addr'(l)] == la[rp + LA_addr'(l)];
    assign in_fire = In_valid && In_ready;
    assign Busy    = state != IDLE;

    always_comb begin
        state_nxt  = state;
        In_ready   = 1'b0;
        Tok_valid  = 1'b0;
        Tok_offset = '0;
        Tok_len    = '0;
        Tok_char   = '0;
        Tok_last   = 1'b0;
        case (state)
            IDLE: begin
                In_ready = 1'b1;
                if (In_valid) state_nxt = FILL;
            end
            FILL: begin
                In_ready = (la_cnt < LA_cw'(LA_num)) && !last_seen;
                if (la_cnt == LA_cw'(LA_num) || (last_seen && la_cnt != '0)) state_nxt = SEARCH;
            end
            SEARCH: if (done) state_nxt = EMIT;
            EMIT: begin
                Tok_valid  = 1'b1;
                Tok_offset = (best_len == '0) ? '0 : best_off;
                Tok_len    = best_len;
                Tok_char   = la[rp + LA_addr'(best_len)];
                Tok_last   = last_seen && (la_cnt == LA_cw'(best_len) + LA_cw'(1));
                if (Tok_ready) state_nxt = SLIDE;
            end
            // best_len doubles as the count of bytes still to move after this one.
            SLIDE: if (best_len == '0) state_nxt = !last_seen ? FILL : (la_cnt == LA_cw'(1)) ? IDLE : SEARCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            wp        <= '0;
            rp        <= '0;
            la_cnt    <= '0;
            hist_cnt  <= '0;
            last_seen <= 1'b0;
            o         <= '0;
            l         <= '0;
            best_len  <= '0;
            best_off  <= '0;
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                la_cnt    <= la_cnt + LA_cw'(1);
                last_seen <= In_last;
            end
            if (state == SEARCH && !done) begin
                if (eq && l < limit) begin
                    l <= l + LEN_width'(1);
                end else begin
                    // Strict compare keeps the smallest offset on ties.
                    if (l > best_len) begin
                        best_len <= l;
                        best_off <= o;
                    end
                    o <= o + OFF_width'(1);
                    l <= '0;
                end
            end
            if (state == SLIDE) begin
                wp       <= wp + WIN_addr'(1);
                rp       <= rp + LA_addr'(1);
                la_cnt   <= la_m1;
                hist_cnt <= (hist_cnt == OFF_width'(WIN_num)) ? hist_cnt : hist_cnt + OFF_width'(1);
                if (best_len != '0) best_len <= best_len - LEN_width'(1);
            end
            if (state_nxt == SEARCH && state != SEARCH) begin
                o        <= OFF_width'(1);
                l        <= '0;
                best_len <= '0;
                best_off <= '0;
            end
            if (state == SLIDE && state_nxt == IDLE) begin
                hist_cnt  <= '0;
                last_seen <= 1'b0;
                best_off  <= '0;
            end
        end
    end

    // Buffer storage carries no reset; the counters above define what is valid.
    always_ff @(posedge Clk) begin
        if (in_fire) la[rp + LA_addr'(la_cnt)] <= Data_in;
        if (state == SLIDE) hist[wp] <= la[rp];
    end
endmodule

// File: tb/tb_lz77_match_encoder.sv
// tb_lz77_match_encoder: directed stimulus with a token scoreboard for lz77_match_encoder
module tb_lz77_match_encoder;
    logic       Clk = 1'b0, Rst = 1'b0, In_valid = 1'b0, In_last = 1'b0, Tok_ready = 1'b0;
    logic [7:0] Data_in = '0;
    logic       In_ready, Tok_valid, Tok_last, Busy;
    logic [6:0] Tok_offset;
    logic [3:0] Tok_len;
    logic [7:0] Tok_char;

    typedef struct packed {
        logic [6:0] off;
        logic [3:0] len;
        logic [7:0] ch;
        logic       last;
    } tok_t;

    tok_t       exp_q[$];
    logic [7:0] stim_q[$];
    int         n_chk = 0, n_fail = 0;

    always #5 Clk = ~Clk;

    lz77_match_encoder dut (
        .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_last(In_last), .Data_in(Data_in),
        .In_ready(In_ready), .Tok_valid(Tok_valid), .Tok_ready(Tok_ready),
        .Tok_offset(Tok_offset), .Tok_len(Tok_len), .Tok_char(Tok_char),
        .Tok_last(Tok_last), .Busy(Busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input int off, input int len, input int ch, input bit last);
        exp_q.push_back({7'(off), 4'(len), 8'(ch), last});
    endtask

    task automatic load(input string s);
        for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
    endtask

    task automatic send_all();
        for (int i = 0; i < stim_q.size(); i++) begin
            int n = 0;
            In_valid = 1'b1;
            Data_in  = stim_q[i];
            In_last  = (i == stim_q.size() - 1);
            while (!In_ready && n < 20000) begin
                step();
                n++;
            end
            if (!In_ready) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
            step();
        end
        In_valid = 1'b0;
        In_last  = 1'b0;
        stim_q.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || Busy) && n < 30000) begin
            step();
            n++;
        end
        check(name, {31'(exp_q.size()), Busy}, 0);
    endtask

    task automatic wait_tok(input string name);
        int n = 0;
        while (!Tok_valid && n < 2000) begin
            step();
            n++;
        end
        check(name, Tok_valid, 1);
    endtask

    // Scoreboard monitor: sampled mid-cycle, a handshake completes at the next rising edge.
    always @(negedge Clk) begin
        if (Rst && Tok_valid && Tok_ready) begin
            if (exp_q.size() == 0) check("unexpected_token", {Tok_offset, Tok_len, Tok_char, Tok_last}, 0);
            else check("token", {Tok_offset, Tok_len, Tok_char, Tok_last}, exp_q.pop_front());
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [19:0] snap;
        repeat (3) step();
        Rst = 1'b1;
        @(negedge Clk);
        check("reset_tok_valid", Tok_valid, 0);
        check("reset_busy", Busy, 0);
        check("reset_in_ready", In_ready, 1);
        check("reset_tok_fields", {Tok_offset, Tok_len, Tok_char, Tok_last}, 0);
        step();

        Tok_ready = 1'b1;
        load("ABC");
        push(0, 0, "A", 0); push(0, 0, "B", 0); push(0, 0, "C", 1);
        send_all();
        drain("drain_literals");

        load("ABABX");
        push(0, 0, "A", 0); push(0, 0, "B", 0); push(2, 2, "X", 1);
        send_all();
        drain("drain_match");

        load("ABABABY");
        push(0, 0, "A", 0); push(0, 0, "B", 0); push(2, 2, "A", 0); push(2, 1, "Y", 1);
        send_all();
        drain("drain_tie_limit");

        Tok_ready = 1'b0;
        load("XY");
        push(0, 0, "X", 0); push(0, 0, "Y", 1);
        send_all();
        wait_tok("bp_tok_valid");
        snap = {Tok_offset, Tok_len, Tok_char, Tok_last};
        repeat (5) begin
            step();
            check("bp_stable", {Tok_valid, In_ready, Tok_offset, Tok_len, Tok_char, Tok_last}, {2'b10, snap});
        end
        Tok_ready = 1'b1;
        drain("drain_backpressure");

        for (int b = 0; b <= 'h45; b++) begin
            stim_q.push_back(8'(b));
            push(0, 0, b, 0);
        end
        stim_q.push_back(8'h06); stim_q.push_back(8'h07); stim_q.push_back(8'h08); stim_q.push_back(8'h50);
        push(64, 3, 'h50, 1);
        send_all();
        drain("drain_wrap");

        Tok_ready = 1'b0;
        load("ABCDEFGH");
        push(0, 0, "A", 0);
        send_all();
        wait_tok("rst_first_tok");
        Tok_ready = 1'b1;
        step();
        Tok_ready = 1'b0;
        step();
        check("rst_busy_before", Busy, 1);
        Rst = 1'b0;
        @(negedge Clk);
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_tok_valid", Tok_valid, 0);
        check("rst_mid_in_ready", In_ready, 1);
        step();
        Rst = 1'b1;
        Tok_ready = 1'b1;
        repeat (20) step();
        check("rst_no_token", {Tok_valid, Busy, 31'(exp_q.size())}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lz77_match_encoder.md
Name: lz77_match_encoder

Overview:
- Downstream of the 64-byte sliding-window RAM stage. Consumes the byte stream that window emits and produces LZ77 triples (offset, length, next char).
- Holds a private circular history buffer of WIN_num bytes and a lookahead buffer of LA_num bytes.
- Performs a serial, one-compare-per-cycle longest-match search.
- Emits one token per match over a valid/ready handshake.

Parameters:
DATA_width, 8, byte width
WIN_num, 64, history depth in bytes
WIN_addr, 6, history address width
LA_num, 16, lookahead depth; max match length = LA_num-1
LEN_width, 4, token length width
OFF_width, 7, token offset width (distance 0..WIN_num)

Ports:
Clk  input  1  single clock, rising edge
Rst  input  1  asynchronous, active-low reset
In_valid  input  1  Data_in valid
In_last  input  1  marks final byte of stream, qualified by In_valid
Data_in  input  8  stream byte
In_ready  output  1  block accepts byte this cycle
Tok_valid  output  1  token valid
Tok_ready  input  1  consumer accepts token
Tok_offset  output  7  match distance back, 1..64; 0 when Tok_len=0
Tok_len  output  4  match length 0..15
Tok_char  output  8  literal following the match
Tok_last  output  1  final token of stream
Busy  output  1  state != IDLE

Behaviour:
- Reset (Rst=0, async): state IDLE; hist_cnt=0; la_cnt=0; last_seen=0. All outputs 0 except In_ready=1. Asserting reset mid-operation discards all buffered data and any pending token.
- Byte transfer occurs on In_valid & In_ready. Token transfer occurs on Tok_valid & Tok_ready.
- FSM states: IDLE, FILL, SEARCH, EMIT, SLIDE.
- IDLE:
  - In_ready=1.
  - An accepted byte is written to lookahead; go to FILL.
  - In_last on this byte sets last_seen.
- FILL:
  - In_ready = (la_cnt<LA_num) & !last_seen.
  - Go to SEARCH when la_cnt==LA_num, or when last_seen & la_cnt>0.
- SEARCH:
  - Candidate offset o runs 1..hist_cnt; compare counter l starts at 0.
  - Each cycle compares hist[wp-o+l] with la[l].
  - limit = min(o, la_cnt-1, LA_num-1). Matches never overlap into the lookahead.
  - If the bytes are equal and l<limit: l++.
  - Otherwise: if l>best_len, set best_len=l and best_off=o (strict >, so the smallest offset wins ties). Then o++, l=0.
  - Go to EMIT when o>hist_cnt, or early when best_len == min(la_cnt-1, LA_num-1).
  - hist_cnt==0 skips directly to EMIT with best_len=0.
  - Worst case is about WIN_num*LA_num cycles.
- EMIT:
  - Tok_valid=1 with Tok_offset=best_off (0 if best_len=0), Tok_len=best_len, Tok_char=la[best_len].
  - Tok_last = last_seen & (la_cnt==best_len+1).
  - Outputs are held stable until Tok_ready; In_ready=0.
  - On the handshake go to SLIDE.
- SLIDE:
  - Moves best_len+1 bytes from lookahead head into history, one per cycle.
  - wp wraps modulo WIN_num; hist_cnt saturates at WIN_num; la_cnt decrements.
  - Afterwards:
    - If last_seen & la_cnt==0: clear hist_cnt, last_seen, best_*; go to IDLE.
    - If last_seen: go to SEARCH.
    - Otherwise: go to FILL.
- Boundaries:
  - Lookahead full: In_ready=0.
  - Offset 64 is legal once hist_cnt=64.
  - In_valid outside FILL/IDLE is ignored (In_ready=0).
  - A Tok_ready asserted with no token pending has no effect.

Test Plan:
- Reset: hold Rst=0, then release -> Tok_valid=0, Busy=0, In_ready=1; pulse Rst low during SEARCH -> Busy=0 next edge, no token emitted.
- Literals: stream "ABC" with In_last on 'C' -> tokens (0,0,'A'), (0,0,'B'), (0,0,'C',Tok_last=1).
- Match: stream "ABABX" -> (0,0,'A'), (0,0,'B'), (2,2,'X',last).
- Tie/limit: stream "ABABABY" -> (0,0,'A'), (0,0,'B'), (2,2,'A'), (2,1,'Y',last); smallest offset chosen on tie.
- Backpressure: Tok_ready=0 for 5 cycles during EMIT -> Tok_offset/len/char stable, In_ready=0, single transfer when Tok_ready=1.
- Window wrap: bytes 0x00..0x45, then 0x06,0x07,0x08,0x50 last -> final token (64,3,0x50,last); a byte 65 back is never matched.
